emulib_ready_valid_rr_arbiter: RTL and testbench

Round-robin arbiter that merges `BRANCHES` ready/valid requesters onto one registered ready/valid output. It is the N-to-1 counterpart of the emulib ready/valid fork and is used where several emulib producers share one downstream channel, such as a trace or DMA request port. Each accepted beat carries its data and source index. The output is a one-entry register with full throughput.

---
 rtl/emulib_ready_valid_rr_arbiter.sv | 119 +++++++++++
 tb/tb_emulib_ready_valid_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/emulib_ready_valid_rr_arbiter.sv
// Round-robin N-to-1 ready/valid arbiter with a one-entry registered output stage.
// Optional packet locking is enabled with `define EMULIB_RV_ARB_LOCK_EN (adds i_last/o_last).
module emulib_ready_valid_rr_arbiter #(
  parameter int BRANCHES   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = $clog2(BRANCHES)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [BRANCHES-1:0]            i_valid,
  output logic [BRANCHES-1:0]            i_ready,
  input  logic [BRANCHES*DATA_WIDTH-1:0] i_data,
`ifdef EMULIB_RV_ARB_LOCK_EN
  input  logic [BRANCHES-1:0]            i_last,
  output logic                           o_last,
`endif
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [SEL_WIDTH-1:0]           o_sel
);

  // Handshake: a beat moves when valid && ready in the same cycle; valid never
  // waits on ready, and a held o_valid keeps o_data/o_sel stable until taken.
  logic                 load;
  logic                 found;
  logic                 in_hs;
  logic                 beat_last;
  logic [BRANCHES-1:0]  grant;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] ptr_next;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [SEL_WIDTH-1:0] cand;
  logic [SEL_WIDTH:0]   sum;
`ifdef EMULIB_RV_ARB_LOCK_EN
  logic                 locked;
  logic [SEL_WIDTH-1:0] lock_sel;
`endif

  assign load = !o_valid || o_ready;

  // Search starts at ptr and wraps; one extra bit in sum holds ptr+i before the modulo fold.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < BRANCHES; i++) begin
      sum = {1'b0, ptr} + (SEL_WIDTH+1)'(i);
      if (sum >= (SEL_WIDTH+1)'(BRANCHES)) begin
        sum = sum - (SEL_WIDTH+1)'(BRANCHES);
      end
      cand = sum[SEL_WIDTH-1:0];
      if (!found && i_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
`ifdef EMULIB_RV_ARB_LOCK_EN
    if (locked) begin
      found     = i_valid[lock_sel];
      grant_idx = lock_sel;
    end
`endif
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    i_ready = '0;
    if (rstn && load) begin
      i_ready = grant;
    end
  end

  always_comb begin
    beat_last = 1'b1;
`ifdef EMULIB_RV_ARB_LOCK_EN
    beat_last = i_last[grant_idx];
`endif
  end

  assign in_hs    = found && load && rstn;
  assign ptr_next = (grant_idx == SEL_WIDTH'(BRANCHES-1)) ? '0 : grant_idx + SEL_WIDTH'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sel    <= '0;
      ptr      <= '0;
`ifdef EMULIB_RV_ARB_LOCK_EN
      o_last   <= 1'b0;
      locked   <= 1'b0;
      lock_sel <= '0;
`endif
    end else begin
      if (in_hs) begin
        o_valid <= 1'b1;
        o_data  <= i_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        o_sel   <= grant_idx;
        // Inside a locked packet the pointer only moves once the last beat is taken.
        if (beat_last) begin
          ptr <= ptr_next;
        end
`ifdef EMULIB_RV_ARB_LOCK_EN
        o_last   <= beat_last;
        locked   <= !beat_last;
        lock_sel <= grant_idx;
`endif
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_emulib_ready_valid_rr_arbiter.sv
// Bench for emulib_ready_valid_rr_arbiter: a 2-way and a 4-way instance, directed
// scenarios plus a randomized run scored against a queue-based reference model.
module tb_emulib_ready_valid_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  int         checks = 0;
  int         failures = 0;

  logic [1:0]  v2, r2;
  logic [15:0] d2;
  logic        ov2, ordy2;
  logic [7:0]  od2;
  logic [0:0]  os2;
  logic [3:0]  v4, r4;
  logic [31:0] d4;
  logic        ov4, ordy4;
  logic [7:0]  od4;
  logic [1:0]  os4;
`ifdef EMULIB_RV_ARB_LOCK_EN
  logic [1:0]  l2 = 2'b11;
  logic [3:0]  l4 = 4'b1111;
  logic        ol2, ol4;
`endif

  always #5 clk = ~clk;

  emulib_ready_valid_rr_arbiter #(.BRANCHES(2), .DATA_WIDTH(8)) dut2 (
    .clk(clk), .rstn(rstn), .i_valid(v2), .i_ready(r2), .i_data(d2),
`ifdef EMULIB_RV_ARB_LOCK_EN
    .i_last(l2), .o_last(ol2),
`endif
    .o_valid(ov2), .o_ready(ordy2), .o_data(od2), .o_sel(os2)
  );

  emulib_ready_valid_rr_arbiter #(.BRANCHES(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rstn(rstn), .i_valid(v4), .i_ready(r4), .i_data(d4),
`ifdef EMULIB_RV_ARB_LOCK_EN
    .i_last(l4), .o_last(ol4),
`endif
    .o_valid(ov4), .o_ready(ordy4), .o_data(od4), .o_sel(os4)
  );

  // Reference: first valid requester at or after ptr, modulo n; -1 when none.
  function automatic int model_grant(int n, logic [3:0] valid, int ptr);
    for (int i = 0; i < n; i++) begin
      if (valid[(ptr + i) % n]) return (ptr + i) % n;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; v2 = 2'b11; d2 = 16'h2211; ordy2 = 1'b1;
    v4 = 4'hF; d4 = 32'h44332211; ordy4 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (r2 !== 2'b00) begin failures++; $display("FAIL reset_ready2 got=%b exp=00", r2); end
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_valid2 got=%b exp=0", ov2); end
    checks++; if (os2 !== 1'b0) begin failures++; $display("FAIL reset_sel2 got=%0d exp=0", os2); end
    checks++; if (od2 !== 8'h00) begin failures++; $display("FAIL reset_data2 got=%h exp=00", od2); end
    checks++; if (r4 !== 4'h0) begin failures++; $display("FAIL reset_ready4 got=%b exp=0000", r4); end
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b exp=0", ov4); end
  endtask

  task automatic test_round_robin();
    int         g;
    logic [7:0] exp_d;
    @(negedge clk);
    rstn = 1'b1; v4 = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      d2 = 16'($urandom);
      #1;
      if (i > 0) begin
        checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL rr_valid beat=%0d got=%b exp=1", i-1, ov2); end
        checks++; if (os2 !== 1'(g)) begin failures++; $display("FAIL rr_sel beat=%0d got=%0d exp=%0d", i-1, os2, g); end
        checks++; if (od2 !== exp_d) begin failures++; $display("FAIL rr_data beat=%0d got=%h exp=%h", i-1, od2, exp_d); end
      end
      if (i == 6) v2 = 2'b00;
      g = i % 2;
      if (i < 6) begin
        checks++; if (r2 !== 2'(1 << g)) begin failures++; $display("FAIL rr_ready beat=%0d got=%b exp=%b", i, r2, 2'(1 << g)); end
        exp_d = d2[g*8 +: 8];
      end
    end
  endtask

  task automatic test_wrap_around();
    @(negedge clk);
    v4 = 4'b1000; d4 = 32'h77000000;
    #1;
    checks++; if (r4 !== 4'b1000) begin failures++; $display("FAIL wrap_ready3 got=%b exp=1000", r4); end
    @(negedge clk);
    v4 = 4'b1001; d4 = 32'h77000010;
    #1;
    checks++; if (ov4 !== 1'b1 || os4 !== 2'd3 || od4 !== 8'h77) begin
      failures++; $display("FAIL wrap_beat3 got=%b/%0d/%h exp=1/3/77", ov4, os4, od4);
    end
    checks++; if (r4 !== 4'b0001) begin failures++; $display("FAIL wrap_ready0 got=%b exp=0001", r4); end
    @(negedge clk);
    v4 = 4'b0000;
    #1;
    checks++; if (os4 !== 2'd0 || od4 !== 8'h10) begin failures++; $display("FAIL wrap_beat0 got=%0d/%h exp=0/10", os4, od4); end
    @(negedge clk);
    #1;
    checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", ov4); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    v2 = 2'b01; d2 = 16'h00A5; ordy2 = 1'b1;
    #1;
    checks++; if (r2 !== 2'b01) begin failures++; $display("FAIL bp_first_ready got=%b exp=01", r2); end
    @(negedge clk);
    v2 = 2'b10; d2 = 16'h3CA5; ordy2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ov2 !== 1'b1 || od2 !== 8'hA5 || r2 !== 2'b00) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/a5/00", i, ov2, od2, r2);
      end
    end
    @(negedge clk);
    ordy2 = 1'b1;
    #1;
    checks++; if (r2 !== 2'b10) begin failures++; $display("FAIL bp_release_ready got=%b exp=10", r2); end
    @(negedge clk);
    v2 = 2'b00;
    #1;
    checks++; if (ov2 !== 1'b1 || od2 !== 8'h3C || os2 !== 1'b1) begin
      failures++; $display("FAIL bp_reload got=%b/%h/%0d exp=1/3c/1", ov2, od2, os2);
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    v2 = 2'b01; d2 = 16'h005A;
    #1;
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL drain_prev got=%b exp=0", ov2); end
    @(negedge clk);
    v2 = 2'b00;
    #1;
    checks++; if (ov2 !== 1'b1 || od2 !== 8'h5A) begin failures++; $display("FAIL drain_beat got=%b/%h exp=1/5a", ov2, od2); end
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", ov2); end
    end
  endtask

  task automatic test_mid_reset();
    // ptr is 1 here; one beat from requester 0 keeps it at 1 while stalled.
    @(negedge clk);
    v2 = 2'b01; d2 = 16'h0099; ordy2 = 1'b0;
    #1;
    checks++; if (r2 !== 2'b01) begin failures++; $display("FAIL mr_ready got=%b exp=01", r2); end
    @(negedge clk);
    v2 = 2'b11;
    #1;
    checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL mr_stalled got=%b exp=1", ov2); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (ov2 !== 1'b0 || od2 !== 8'h00 || r2 !== 2'b00) begin
      failures++; $display("FAIL mr_async got=%b/%h/%b exp=0/00/00", ov2, od2, r2);
    end
    @(negedge clk);
    rstn = 1'b1; ordy2 = 1'b1;
    #1;
    checks++; if (r2 !== 2'b01) begin failures++; $display("FAIL mr_ptr_zero got=%b exp=01", r2); end
    @(negedge clk);
    v2 = 2'b00;
    @(negedge clk);
  endtask

`ifdef EMULIB_RV_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] vv[4];
    logic [1:0] ll[4];
    logic [1:0] er[4];
    vv = '{2'b01, 2'b11, 2'b11, 2'b10};
    ll = '{2'b10, 2'b10, 2'b11, 2'b11};
    er = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin v2 = vv[i]; l2 = ll[i]; d2 = {8'hB0, 8'(8'hA0 + i)}; end
      else v2 = 2'b00;
      #1;
      if (i < 4) begin
        checks++; if (r2 !== er[i]) begin failures++; $display("FAIL lock_ready cyc=%0d got=%b exp=%b", i, r2, er[i]); end
      end
      if (i > 0) begin
        checks++; if (os2 !== ((i == 4) ? 1'b1 : 1'b0) || ol2 !== ((i == 1 || i == 2) ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL lock_beat cyc=%0d got sel=%0d last=%b", i, os2, ol2);
        end
      end
    end
    l2 = 2'b11;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    logic [9:0] exp_q[$];
    logic [9:0] exp_beat;
    int         m_ptr = 0;
    bit         m_ov = 1'b0;
    int         g;
    bit         load;
    logic [3:0] exp_r;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      v4 = 4'($urandom_range(0, 15));
      d4 = $urandom;
      ordy4 = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant(4, v4, m_ptr);
      load = !m_ov || ordy4;
      exp_r = (g >= 0 && load) ? 4'(1 << g) : 4'h0;
      checks++; if (r4 !== exp_r) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, r4, exp_r); end
      checks++; if (ov4 !== m_ov) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, ov4, m_ov); end
      if (m_ov && ordy4) begin
        if (exp_q.size() == 0) begin
          failures++; checks++; $display("FAIL rand_queue_empty cyc=%0d", c);
        end else begin
          exp_beat = exp_q.pop_front();
          checks++; if ({os4, od4} !== exp_beat) begin
            failures++; $display("FAIL rand_beat cyc=%0d got=%0d/%h exp=%0d/%h", c, os4, od4, exp_beat[9:8], exp_beat[7:0]);
          end
        end
      end
      if (g >= 0 && load) begin
        exp_q.push_back({2'(g), d4[g*8 +: 8]});
        m_ptr = (g + 1) % 4;
        m_ov = 1'b1;
      end else if (m_ov && ordy4) begin
        m_ov = 1'b0;
      end
    end
    v4 = 4'h0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap_around();
    test_backpressure();
    test_drain();
    test_mid_reset();
`ifdef EMULIB_RV_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
